// File: rtl/axi_write_burst_sequencer.sv
// Expands one merged AXI write burst into per-beat cache write commands and
// returns the B response once the final beat has been handed to the cache.
module axi_write_burst_sequencer #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic [ID_W-1:0]     i_req_id,
    input  logic [1:0]          i_req_burst,
    input  logic [2:0]          i_req_size,
    input  logic [7:0]          i_req_len,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_wstrb,
    input  logic                i_wlast,
    input  logic                i_wvalid,
    output logic                o_wready,
    output logic                o_cw_valid,
    input  logic                i_cw_ready,
    output logic [ADDR_W-1:0]   o_cw_addr,
    output logic [DATA_W-1:0]   o_cw_data,
    output logic [DATA_W/8-1:0] o_cw_strb,
    output logic                o_cw_last,
    output logic                o_bvalid,
    input  logic                i_bready,
    output logic [ID_W-1:0]     o_bid,
    output logic [1:0]          o_bresp
);
    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned SIZE_MAX = $clog2(STRB_W);

    typedef enum logic [1:0] {S_IDLE, S_BEAT, S_RESP} state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_id;
    logic [1:0]        r_burst;
    logic [2:0]        r_size;
    logic [7:0]        r_len;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_cnt;
    logic              r_req_err;
    logic              r_err;

    logic              w_wrap_len_ok;
    logic              w_req_err;
    logic              w_in_beat;
    logic              w_last_beat;
    logic              w_beat_hs;
    logic [ADDR_W-1:0] w_incr;
    logic [ADDR_W-1:0] w_wmask;
    logic [ADDR_W-1:0] w_next_addr;

    // Malformed requests are drained without issuing cache commands.
    assign w_wrap_len_ok = (i_req_len == 8'd1) || (i_req_len == 8'd3) ||
                           (i_req_len == 8'd7) || (i_req_len == 8'd15);
    assign w_req_err     = (i_req_burst == 2'b11) ||
                           (i_req_size > 3'(SIZE_MAX)) ||
                           ((i_req_burst == 2'b10) && !w_wrap_len_ok);

    assign w_in_beat   = (r_state == S_BEAT);
    assign w_last_beat = (r_cnt == r_len);
    assign w_beat_hs   = i_wvalid & o_wready;

    // Legal WRAP lengths make (len+1) a power of two, so the wrap window is a shift.
    assign w_incr  = ADDR_W'(1) << r_size;
    assign w_wmask = ((ADDR_W'(r_len) + ADDR_W'(1)) << r_size) - ADDR_W'(1);

    always_comb begin
        w_next_addr = r_addr;
        case (r_burst)
            2'b01:   w_next_addr = (r_addr & ~(w_incr - ADDR_W'(1))) + w_incr;
            2'b10:   w_next_addr = (r_addr & ~w_wmask) | ((r_addr + w_incr) & w_wmask);
            default: w_next_addr = r_addr;
        endcase
    end

    assign o_req_ready = (r_state == S_IDLE);
    assign o_cw_valid  = w_in_beat & ~r_req_err & i_wvalid;
    assign o_wready    = w_in_beat & (r_req_err | i_cw_ready);
    assign o_cw_addr   = r_addr;
    assign o_cw_data   = i_wdata;
    assign o_cw_strb   = i_wstrb;
    assign o_cw_last   = w_in_beat & w_last_beat;
    assign o_bvalid    = (r_state == S_RESP);
    assign o_bid       = r_id;
    assign o_bresp     = (o_bvalid && r_err) ? 2'b10 : 2'b00;

    // Burst control: beat count, not wlast, decides when the burst ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_id      <= '0;
            r_burst   <= '0;
            r_size    <= '0;
            r_len     <= '0;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_req_err <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_id      <= i_req_id;
                        r_burst   <= i_req_burst;
                        r_size    <= i_req_size;
                        r_len     <= i_req_len;
                        r_addr    <= i_req_addr;
                        r_cnt     <= 8'd0;
                        r_req_err <= w_req_err;
                        r_err     <= w_req_err;
                        r_state   <= S_BEAT;
                    end
                end
                S_BEAT: begin
                    if (w_beat_hs) begin
                        r_cnt  <= r_cnt + 8'd1;
                        r_addr <= w_next_addr;
                        if (i_wlast != w_last_beat) begin
                            r_err <= 1'b1;
                        end
                        if (w_last_beat) begin
                            r_state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (i_bready) begin
                        r_err     <= 1'b0;
                        r_req_err <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/axi_write_burst_sequencer.md
# axi_write_burst_sequencer

Downstream stage of the AW/W merger in the AXI-MM cache write path. Accepts one merged write request (AW fields) plus its W beats and expands the burst into per-beat cache write commands, each carrying a computed beat address. After the last beat it returns the AXI B response. One burst is in flight at a time.

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, data width; DATA_W/8 strobe bits; legal 32..1024, power of two
- ID_W, 4, transaction ID width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  merged AW request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_addr  in  ADDR_W  start address
- req_id  in  ID_W  transaction ID
- req_burst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- req_size  in  3  bytes per beat = 1<<req_size
- req_len  in  8  beats - 1
- wdata / wstrb / wlast / wvalid  in  DATA_W / DATA_W/8 / 1 / 1  W beat
- wready  out  1  W beat accepted
- cw_valid  out  1  cache write command valid
- cw_ready  in  1  cache accepts command
- cw_addr / cw_data / cw_strb / cw_last  out  ADDR_W / DATA_W / DATA_W/8 / 1  command fields
- bvalid  out  1  write response valid
- bready  in  1  response accepted
- bid  out  ID_W  response ID (latched req_id)
- bresp  out  2  00 OKAY, 10 SLVERR

## Operation
- FSM states IDLE, BEAT, RESP. Reset state IDLE.
- IDLE: req_ready=1. On handshake latch id, burst, size, len; cur_addr=req_addr; beat_cnt=0; err computed from request; go to BEAT.
- Request error (err=1) if: burst==11; 1<<size > DATA_W/8; WRAP with len not in {1,3,7,15}.
- BEAT, err=0: cw_valid=wvalid, wready=cw_ready; cw_data/cw_strb pass through combinationally from wdata/wstrb; cw_addr=cur_addr; cw_last=(beat_cnt==len).
- BEAT, err=1: cw_valid=0, wready=1 (beats drained and discarded).
- Beat handshake (wvalid & wready): beat_cnt+1, cur_addr updated; when beat_cnt==len go to RESP.
- wlast check: wlast on a beat with beat_cnt!=len, or wlast=0 on the final beat, sets err (sticky for burst). Termination always by beat_cnt, never by wlast.
- Address update, incr=1<<size, arithmetic modulo 2^ADDR_W:
  - FIXED: unchanged.
  - INCR: next = (cur_addr & ~(incr-1)) + incr (first beat unaligned, later beats aligned). No 4 KB check.
  - WRAP: wsz=incr*(len+1); next = (cur_addr & ~(wsz-1)) | ((cur_addr+incr) & (wsz-1)).
- RESP: bvalid=1, bid=latched id, bresp = err ? 10 : 00. On bready go to IDLE, clear err.
- Reset mid-burst: return to IDLE immediately; in-flight burst dropped, no B response.

## Timing
- Reset values: req_ready=1 after reset (IDLE), wready=0, cw_valid=0, cw_last=0, cw_addr=0, bvalid=0, bid=0, bresp=00.
- Request accepted cycle N; first beat may hand off in cycle N+1. Zero-cycle W->cw latency; throughput 1 beat/cycle.
- bvalid asserts cycle after final beat handshake; held with stable bid/bresp until bready.
- req_ready=0 in BEAT and RESP; next request accepted earliest cycle after B handshake.
- cw_valid never depends on cw_ready; wready may depend on cw_ready (combinational).
- cw_ready low stalls: cw_addr/cw_data held stable while wvalid held.

## Test plan
- INCR, addr 0x1004, size 3, len 3, cw_ready=1 -> cw_addr 0x1004,0x1008,0x1010,0x1018; cw_last on 4th; bresp 00, bid = req_id.
- WRAP, addr 0x38, size 3, len 3 -> cw_addr 0x38,0x20,0x28,0x30; bresp 00.
- FIXED, addr 0x200, len 2, cw_ready toggling every cycle -> three commands all at 0x200, data order preserved, no drops.
- Burst 11 (or size 4 with DATA_W=64), len 1 -> two W beats accepted, cw_valid never 1, bresp 10.
- INCR len 3 with wlast on beat 2 -> 4 commands issued, bresp 10; bready held low 5 cycles -> bvalid/bid/bresp stable, req_ready 0.
- rst_n low after beat 1 of len 3 -> all outputs at reset values, no bvalid; new request after reset completes normally.
